// File: rtl/seq_stepper.sv
// seq_stepper: prescaled reversible stepper through binary, Gray or Johnson codes,
// with synchronous load and Johnson illegal-state recovery flagged on Err.
module seq_stepper #(
    parameter int W         = 4,
    parameter int DIV       = 50_000_000,
    parameter int RESET_VAL = 0
) (
    input  logic         CP,
    input  logic         nCR,
    input  logic         Sin,
    input  logic         En,
    input  logic [1:0]   Mode,
    input  logic         Load,
    input  logic [W-1:0] Din,
    output logic [W-1:0] Out,
    output logic         Tick,
    output logic         Err
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    logic [W-1:0]  bin, bin_next, gray_next, john_next, next_out;
    logic [W-2:0]  diff;
    logic          illegal, step;
    assign Tick = cnt == CW'(DIV - 1);
    assign step = Tick && En && !Load && Mode != 2'b11;
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) bin[i] = ^(Out >> i);
        bin_next  = Sin ? bin + W'(1) : bin - W'(1);
        gray_next = bin_next ^ (bin_next >> 1);
        john_next = Sin ? {Out[W-2:0], ~Out[W-1]} : {~Out[0], Out[W-1:1]};
        // a legal Johnson word has at most one boundary between runs of equal bits
        diff      = Out[W-2:0] ^ Out[W-1:1];
        illegal   = |(diff & (diff - (W-1)'(1)));
        next_out  = Mode == 2'b00 ? (Sin ? Out + W'(1) : Out - W'(1)) :
                    Mode == 2'b01 ? gray_next :
                    illegal       ? '0 : john_next;
    end
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            cnt <= '0;
            Out <= W'(RESET_VAL);
            Err <= 1'b0;
        end else begin
            cnt <= Tick ? '0 : cnt + CW'(1);
            Out <= Load ? Din : step ? next_out : Out;
            Err <= step && Mode == 2'b10 && illegal;
        end
    end
endmodule
